// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select, IF/ID pipeline register, stall/flush counters.
// Latency: 1 cycle from PC to IF/ID; imem_addr is the PC register with no extra fetch delay.
// Backpressure: DataHazard freezes PC and IF/ID; exceptions override it; redirects wait until it clears.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DataHazard,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [2:0] SRC_SEQ    = 3'b000;
    localparam logic [2:0] SRC_BRANCH = 3'b001;
    localparam logic [2:0] SRC_JR     = 3'b010;
    localparam logic [2:0] SRC_JUMP   = 3'b011;
    localparam logic [2:0] SRC_ILLOP  = 3'b100;
    localparam logic [2:0] SRC_XADR   = 3'b101;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] pc_plus4_q,    pc_plus4_d;
    logic        valid_q,       valid_d;
    logic [15:0] stall_cnt_q,   stall_cnt_d;
    logic [15:0] flush_cnt_q,   flush_cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        is_exc;
    logic        is_stall;
    logic        is_redirect;

    // Jumps keep the current supervisor bit, so the target's MSB is never used.
    logic        unused_jump_msb;
    assign unused_jump_msb = jump_target[31];

    // Sequential PC: supervisor bit is sticky, the low 31 bits wrap on their own.
    always_comb begin
        pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
    end

    // Next-PC target mux; the unused codes fall back to sequential fetch.
    always_comb begin
        target = pc_plus4;
        case (PCSrc)
            SRC_BRANCH: target = branch_target;
            SRC_JR:     target = jr_target;
            SRC_JUMP:   target = {pc_q[31], jump_target[30:0]};
            SRC_ILLOP:  target = ILLOP_VEC;
            SRC_XADR:   target = XADR_VEC;
            default:    target = pc_plus4;
        endcase
    end

    // Cycle classification: exception beats stall, stall beats redirect.
    always_comb begin
        is_exc      = (PCSrc == SRC_ILLOP) || (PCSrc == SRC_XADR);
        is_stall    = !is_exc && DataHazard;
        is_redirect = !is_exc && !DataHazard &&
                      ((PCSrc == SRC_BRANCH) || (PCSrc == SRC_JR) || (PCSrc == SRC_JUMP));
    end

    // Next state for PC, IF/ID and the saturating event counters.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (is_exc || is_redirect) begin
            // Squash the instruction fetched this cycle; there is no delay slot.
            pc_d        = target;
            instr_d     = 32'h0000_0000;
            pc_plus4_d  = pc_plus4;
            valid_d     = 1'b0;
            flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + 16'd1;
        end else if (is_stall) begin
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + 16'd1;
        end else begin
            pc_d        = pc_plus4;
            instr_d     = imem_rdata;
            pc_plus4_d  = pc_plus4;
            valid_d     = 1'b1;
        end
    end

    // State registers; reset also drops any redirect that was waiting on a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0000_0000;
            pc_plus4_q  <= 32'h0000_0000;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc_plus4_q;
    assign if_id_valid    = valid_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule
